col_switch_sequencer: RTL and testbench

- Digital control-side counterpart of the column driver. Turns single-cycle operation commands (READ / SET / RESET) into timed, mutually exclusive, break-before-make switch-enable waveforms on SWref, SWc_plus and SWc_minus.
- Sits between the user-project command logic (Wishbone/logic-analyzer side) and the column driver's GPIO switch inputs.
- Guarantees:
  - at most one switch is enabled in any cycle;
  - a dead-time is inserted before and after every pulse.

---
 rtl/col_switch_sequencer.sv | 150 +++++++++++++++
 tb/tb_col_switch_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/col_switch_sequencer.sv
// Break-before-make sequencer: turns READ/SET/RESET commands into timed,
// mutually exclusive enables for SWref, SWc_plus and SWc_minus.
module col_switch_sequencer #(
    parameter int unsigned DEAD_CYC = 2,
    parameter int unsigned WIDTH_W  = 8,
    parameter int unsigned REP_W    = 4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [WIDTH_W-1:0] cmd_width,
    input  logic [REP_W-1:0]   cmd_reps,
    input  logic               abort,
    output logic               SWref,
    output logic               SWc_plus,
    output logic               SWc_minus,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               err,
    output logic [REP_W-1:0]   pulse_cnt
);

    localparam int unsigned DCNT_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [DCNT_W-1:0] DEAD_LAST = DCNT_W'(DEAD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GUARD_PRE,
        S_PULSE,
        S_GUARD_POST,
        S_ABORT_GUARD,
        S_DONE
    } state_t;

    state_t             state;
    logic [1:0]         op_q;
    logic [WIDTH_W-1:0] width_q;
    logic [WIDTH_W-1:0] wcnt;
    logic [REP_W-1:0]   reps_left;
    logic [DCNT_W-1:0]  dcnt;
    logic [2:0]         sw_q;

    // {minus, plus, ref} one-hot enable for a latched opcode
    function automatic logic [2:0] sw_sel(input logic [1:0] op);
        case (op)
            2'd0:    sw_sel = 3'b001;
            2'd1:    sw_sel = 3'b010;
            2'd2:    sw_sel = 3'b100;
            default: sw_sel = 3'b000;
        endcase
    endfunction

    assign cmd_ready = (state == S_IDLE);
    assign SWref     = sw_q[0];
    assign SWc_plus  = sw_q[1];
    assign SWc_minus = sw_q[2];

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state     <= S_IDLE;
            op_q      <= 2'd0;
            width_q   <= '0;
            wcnt      <= '0;
            reps_left <= '0;
            dcnt      <= '0;
            sw_q      <= 3'b000;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            err       <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_op == 2'd3 || cmd_width == '0) begin
                            err <= 1'b1;
                        end else begin
                            op_q      <= cmd_op;
                            width_q   <= cmd_width;
                            reps_left <= (cmd_reps == '0) ? REP_W'(1) : cmd_reps;
                            pulse_cnt <= '0;
                            busy      <= 1'b1;
                            aborted   <= 1'b0;
                            dcnt      <= DEAD_LAST;
                            state     <= S_GUARD_PRE;
                        end
                    end
                end
                S_GUARD_PRE, S_PULSE, S_GUARD_POST: begin
                    if (abort) begin
                        // a pulse aborted on its final high cycle still counts as full
                        if (state == S_PULSE && wcnt == '0)
                            pulse_cnt <= pulse_cnt + REP_W'(1);
                        sw_q  <= 3'b000;
                        dcnt  <= DEAD_LAST;
                        state <= S_ABORT_GUARD;
                    end else if (state == S_PULSE) begin
                        if (wcnt == '0) begin
                            sw_q      <= 3'b000;
                            pulse_cnt <= pulse_cnt + REP_W'(1);
                            dcnt      <= DEAD_LAST;
                            state     <= S_GUARD_POST;
                        end else begin
                            wcnt <= wcnt - WIDTH_W'(1);
                        end
                    end else if (dcnt != '0) begin
                        dcnt <= dcnt - DCNT_W'(1);
                    end else if (state == S_GUARD_PRE || reps_left > REP_W'(1)) begin
                        if (state == S_GUARD_POST)
                            reps_left <= reps_left - REP_W'(1);
                        sw_q  <= sw_sel(op_q);
                        wcnt  <= width_q - WIDTH_W'(1);
                        state <= S_PULSE;
                    end else begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_ABORT_GUARD: begin
                    if (dcnt == '0) begin
                        done    <= 1'b1;
                        aborted <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        dcnt <= dcnt - DCNT_W'(1);
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    aborted <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    sw_q    <= 3'b000;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    aborted <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_col_switch_sequencer.sv
// Self-checking bench for col_switch_sequencer: directed and random commands
// compared cycle by cycle against a timing model derived from pulse arithmetic.
module tb_col_switch_sequencer;

    localparam int D  = 2;
    localparam int WW = 8;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [WW-1:0] cmd_width = '0;
    logic [RW-1:0] cmd_reps = '0;
    logic          abort = 1'b0;
    logic          SWref, SWc_plus, SWc_minus;
    logic          busy, done, aborted, err;
    logic [RW-1:0] pulse_cnt;

    int n_cmp = 0;
    int n_mis = 0;
    int off_run = 0;
    int last_gap = -1;
    bit prev_on = 1'b0;
    bit seen_on = 1'b0;

    col_switch_sequencer #(.DEAD_CYC(D), .WIDTH_W(WW), .REP_W(RW)) dut (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_width(cmd_width),
        .cmd_reps (cmd_reps),
        .abort    (abort),
        .SWref    (SWref),
        .SWc_plus (SWc_plus),
        .SWc_minus(SWc_minus),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .err      (err),
        .pulse_cnt(pulse_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-hot and dead-time watch over the whole run
    always @(negedge clk) begin
        if (rst_n) begin
            int on;
            on = int'(SWref) + int'(SWc_plus) + int'(SWc_minus);
            chk("one_hot", 32'(on <= 1), 32'd1);
            if (on != 0) begin
                if (!prev_on && seen_on) begin
                    chk("dead_gap", 32'(off_run >= D), 32'd1);
                    last_gap = off_run;
                end
                off_run = 0;
                seen_on = 1'b1;
            end else begin
                off_run++;
            end
            prev_on = (on != 0);
        end
    end

    // Drive one legal command and check every cycle until its done pulse.
    // ab>0 asserts abort at that cycle; keep_valid presents the next command early.
    task automatic run_cmd(input logic [1:0] op, input int w, input int r, input int ab,
                           input bit keep_valid, input logic [1:0] nop, input int nw, input int nr);
        int rr, period, endc, m, pc, last;
        bit hi;
        @(negedge clk);
        chk("idle_ready", 32'(cmd_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_width = WW'(w);
        cmd_reps  = RW'(r);
        abort     = 1'($urandom_range(0, 1));
        rr     = (r == 0) ? 1 : r;
        period = w + D;
        endc   = (ab > 0) ? ab + D + 1 : rr * period + D + 1;
        for (int n = 1; n <= endc; n++) begin
            @(negedge clk);
            if (keep_valid) begin
                cmd_op    = nop;
                cmd_width = WW'(nw);
                cmd_reps  = RW'(nr);
            end else begin
                cmd_valid = 1'b0;
                cmd_op    = 2'($urandom);
                cmd_width = WW'($urandom);
                cmd_reps  = RW'($urandom);
            end
            abort = (n == ab);
            m  = n - D - 1;
            hi = (m >= 0) && (m / period < rr) && (m % period < w) && (ab == 0 || n <= ab);
            pc = 0;
            for (int k = 0; k < rr; k++) begin
                last = D + w + k * period;
                if (last < n && (ab == 0 || last <= ab)) pc++;
            end
            chk($sformatf("sw@%0d", n), 32'({SWc_minus, SWc_plus, SWref}),
                32'(hi ? (3'b001 << op) : 3'b000));
            chk($sformatf("busy@%0d", n), 32'(busy), 32'd1);
            chk($sformatf("ready@%0d", n), 32'(cmd_ready), 32'd0);
            chk($sformatf("done@%0d", n), 32'(done), 32'(n == endc));
            chk($sformatf("aborted@%0d", n), 32'(aborted), 32'(n == endc && ab > 0));
            chk($sformatf("err@%0d", n), 32'(err), 32'd0);
            chk($sformatf("pulse_cnt@%0d", n), 32'(pulse_cnt), 32'(pc));
        end
        abort = 1'b0;
    endtask

    task automatic run_illegal(input logic [1:0] op, input int w);
        @(negedge clk);
        chk("ill_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_width = WW'(w);
        cmd_reps  = RW'($urandom);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            chk($sformatf("ill_err@%0d", n), 32'(err), 32'(n == 1));
            chk($sformatf("ill_busy@%0d", n), 32'(busy), 32'd0);
            chk($sformatf("ill_done@%0d", n), 32'(done), 32'd0);
            chk($sformatf("ill_sw@%0d", n), 32'({SWc_minus, SWc_plus, SWref}), 32'd0);
            chk($sformatf("ill_ready@%0d", n), 32'(cmd_ready), 32'd1);
        end
    endtask

    initial begin
        int w, r, ab, normal_end, waited;
        logic [1:0] op;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_sw", 32'({SWc_minus, SWc_plus, SWref}), 32'd0);
        chk("rst_flags", 32'({busy, done, aborted, err}), 32'd0);
        chk("rst_pulse_cnt", 32'(pulse_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);

        run_cmd(2'd1, 3, 1, 0, 1'b0, 2'd0, 0, 0);
        run_cmd(2'd0, 1, 2, 0, 1'b0, 2'd0, 0, 0);
        run_illegal(2'd3, 5);
        run_illegal(2'd1, 0);
        run_cmd(2'd2, 10, 1, 5, 1'b0, 2'd0, 0, 0);
        run_cmd(2'd2, 255, 15, 0, 1'b0, 2'd0, 0, 0);

        // Random legal commands, some aborted, reps=0 included
        for (int i = 0; i < 14; i++) begin
            op = 2'($urandom_range(0, 2));
            w  = $urandom_range(1, 6);
            r  = $urandom_range(0, 4);
            normal_end = ((r == 0) ? 1 : r) * (w + D) + D + 1;
            ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, normal_end - 1) : 0;
            run_cmd(op, w, r, ab, 1'b0, 2'd0, 0, 0);
        end

        // Back-to-back with cmd_valid held high
        run_cmd(2'd1, 4, 2, 0, 1'b1, 2'd2, 3, 1);
        run_cmd(2'd2, 3, 1, 0, 1'b0, 2'd0, 0, 0);
        chk("b2b_gap", 32'(last_gap), 32'(2 * D + 2));

        // Asynchronous reset in the middle of a pulse
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_width = WW'(20);
        cmd_reps  = RW'(1);
        @(negedge clk);
        cmd_valid = 1'b0;
        waited = 0;
        while (!SWc_plus && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("mid_pulse_reached", 32'(SWc_plus), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_sw", 32'({SWc_minus, SWc_plus, SWref}), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_cnt", 32'(pulse_cnt), 32'd0);
        run_cmd(2'd0, 2, 1, 0, 1'b0, 2'd0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
